// File: rtl/layer_input_stage.sv
// Multi-bank input stage: edge-armed capture of whole input vectors into a small FIFO of
// banks, so the next layer can compute on the head vector while the following one lands.
module layer_input_stage #(
    parameter int WEIGHT_NO  = 784,
    parameter int DATA_WIDTH = 16,
    parameter int BANKS      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            done_in,
    input  logic                            first,
    input  logic [WEIGHT_NO*DATA_WIDTH-1:0] in,
    input  logic                            out_ack,
    output logic [WEIGHT_NO*DATA_WIDTH-1:0] out,
    output logic                            out_valid,
    output logic [$clog2(BANKS+1)-1:0]      occupancy,
    output logic                            full,
    output logic                            overflow
);
    localparam int VEC_W = WEIGHT_NO * DATA_WIDTH;
    localparam int PTR_W = $clog2(BANKS);
    localparam int OCC_W = $clog2(BANKS + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BANKS);

    logic [VEC_W-1:0] r_bank [BANKS];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [OCC_W-1:0] r_occ;
    logic             r_armed;
    logic             r_overflow;

    logic w_level;
    logic w_trig;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_level = done_in | first;
    assign w_trig  = r_armed & w_level;
    assign w_full  = (r_occ == OCC_FULL);
    assign w_empty = (r_occ == '0);
    assign w_pop   = out_ack & ~w_empty;
    // When full, a same-cycle pop frees the head slot, so the capture still lands.
    assign w_push  = w_trig & (~w_full | out_ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_occ      <= '0;
            r_armed    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_trig) begin
                r_armed <= 1'b0;
            end else if (!w_level) begin
                r_armed <= 1'b1;
            end

            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end

            if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - OCC_W'(1);
            end

            if (w_trig && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Bank storage carries no reset; validity is tracked solely by the occupancy count.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_bank[r_wrPtr] <= in;
        end
    end

    assign out_valid = ~w_empty;
    assign out       = w_empty ? '0 : r_bank[r_rdPtr];
    assign occupancy = r_occ;
    assign full      = w_full;
    assign overflow  = r_overflow;

endmodule
